// File: rtl/hazard_ctrl.sv
// hazard_ctrl
// Central stall/flush generator for the five-stage RV32 pipeline. Detects
// load-use hazards, EX-stage redirects and data-memory wait states, runs a
// data-memory wait FSM with a timeout trap, and keeps saturating stall and
// flush performance counters.
module hazard_ctrl #(
    parameter int XLEN         = 32,
    parameter int CNT_W        = 32,
    parameter int DMEM_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1_addr,
    input  logic [4:0]       id_rs2_addr,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd_addr,
    input  logic             ex_mem_read,
    input  logic             ex_redirect,
    input  logic [XLEN-1:0]  ex_redirect_target,
    input  logic             mem_req,
    input  logic             dmem_ready,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             id_ex_stall,
    output logic             ex_mem_stall,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_wb_flush,
    output logic             pc_redirect,
    output logic [XLEN-1:0]  pc_redirect_target,
    output logic [1:0]       state,
    output logic             dmem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_e;

    // Wide enough to hold DMEM_TIMEOUT itself so the timeout compare never truncates.
    localparam int WCW = $clog2(DMEM_TIMEOUT + 1);

    state_e             state_q, state_d;
    logic [WCW-1:0]     waitCnt_q, waitCnt_d;
    logic [CNT_W-1:0]   stallCycles_q, flushEvents_q;
    logic               loadUse;
    logic               memWait;

    // A load in EX whose destination is read by the ID instruction; x0 never creates a hazard.
    assign loadUse = ex_mem_read && (ex_rd_addr != 5'd0) &&
                     ((id_uses_rs1 && (id_rs1_addr == ex_rd_addr)) ||
                      (id_uses_rs2 && (id_rs2_addr == ex_rd_addr)));
    assign memWait = mem_req && !dmem_ready;

    assign pc_redirect_target = ex_redirect_target;
    assign state              = state_q;
    assign dmem_timeout       = (state_q == ERROR);
    assign stall_cycles       = stallCycles_q;
    assign flush_events       = flushEvents_q;

    // Prioritised control outputs: memory wait freezes everything, then redirect, then load-use bubble.
    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        id_ex_stall  = 1'b0;
        ex_mem_stall = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        mem_wb_flush = 1'b0;
        pc_redirect  = 1'b0;
        if (state_q == ERROR || memWait) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
            mem_wb_flush = 1'b1;
        end else if (ex_redirect) begin
            pc_redirect = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (loadUse) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
        end
    end

    // Next state for the data-memory wait FSM; ERROR is left only through reset.
    always_comb begin
        state_d   = state_q;
        waitCnt_d = waitCnt_q;
        case (state_q)
            RUN: begin
                if (memWait) begin
                    state_d   = MEM_WAIT;
                    waitCnt_d = WCW'(1);
                end
            end
            MEM_WAIT: begin
                if (dmem_ready || !mem_req) begin
                    state_d   = RUN;
                    waitCnt_d = '0;
                end else if ((waitCnt_q + WCW'(1)) == WCW'(DMEM_TIMEOUT)) begin
                    state_d = ERROR;
                end else begin
                    waitCnt_d = waitCnt_q + WCW'(1);
                end
            end
            ERROR: begin
                state_d = ERROR;
            end
            default: begin
                state_d   = RUN;
                waitCnt_d = '0;
            end
        endcase
    end

    // State and wait counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= RUN;
            waitCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            waitCnt_q <= waitCnt_d;
        end
    end

    // Saturating performance counters, frozen once the timeout trap has fired.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stallCycles_q <= '0;
            flushEvents_q <= '0;
        end else if (state_q != ERROR) begin
            if (pc_stall && (stallCycles_q != '1)) begin
                stallCycles_q <= stallCycles_q + CNT_W'(1);
            end
            if (pc_redirect && (flushEvents_q != '1)) begin
                flushEvents_q <= flushEvents_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl
// Table-driven combinational checks of the hazard priorities plus directed
// multi-cycle sequences for memory wait, timeout, counters and async reset.
module tb_hazard_ctrl;

    localparam int XLEN  = 32;
    localparam int CNT_W = 32;
    localparam int TMO   = 4;

    logic             clk;
    logic             reset;
    logic [4:0]       id_rs1_addr;
    logic [4:0]       id_rs2_addr;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    logic [4:0]       ex_rd_addr;
    logic             ex_mem_read;
    logic             ex_redirect;
    logic [XLEN-1:0]  ex_redirect_target;
    logic             mem_req;
    logic             dmem_ready;
    logic             pc_stall;
    logic             if_id_stall;
    logic             id_ex_stall;
    logic             ex_mem_stall;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             mem_wb_flush;
    logic             pc_redirect;
    logic [XLEN-1:0]  pc_redirect_target;
    logic [1:0]       state;
    logic             dmem_timeout;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;

    int errorCount = 0;
    int checkCount = 0;

    typedef struct {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        uses1;
        logic        uses2;
        logic [4:0]  exRd;
        logic        exLoad;
        logic        redirect;
        logic [31:0] target;
        logic        memReq;
        logic        ready;
    } stim_t;

    // Expected control bits, in order:
    // pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush, id_ex_flush, mem_wb_flush, pc_redirect
    typedef struct {
        string      name;
        stim_t      stim;
        logic [7:0] expCtrl;
    } vector_t;

    localparam logic [7:0] CTRL_NONE     = 8'b0000_0000;
    localparam logic [7:0] CTRL_LOADUSE  = 8'b1100_0100;
    localparam logic [7:0] CTRL_REDIRECT = 8'b0000_1101;
    localparam logic [7:0] CTRL_MEMWAIT  = 8'b1111_0010;

    stim_t   idle;
    vector_t vectors[12];

    hazard_ctrl #(
        .XLEN(XLEN),
        .CNT_W(CNT_W),
        .DMEM_TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .id_rs1_addr(id_rs1_addr),
        .id_rs2_addr(id_rs2_addr),
        .id_uses_rs1(id_uses_rs1),
        .id_uses_rs2(id_uses_rs2),
        .ex_rd_addr(ex_rd_addr),
        .ex_mem_read(ex_mem_read),
        .ex_redirect(ex_redirect),
        .ex_redirect_target(ex_redirect_target),
        .mem_req(mem_req),
        .dmem_ready(dmem_ready),
        .pc_stall(pc_stall),
        .if_id_stall(if_id_stall),
        .id_ex_stall(id_ex_stall),
        .ex_mem_stall(ex_mem_stall),
        .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush),
        .mem_wb_flush(mem_wb_flush),
        .pc_redirect(pc_redirect),
        .pc_redirect_target(pc_redirect_target),
        .state(state),
        .dmem_timeout(dmem_timeout),
        .stall_cycles(stall_cycles),
        .flush_events(flush_events)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t mkStim(input logic [4:0] rs1, input logic [4:0] rs2,
                                     input logic uses1, input logic uses2,
                                     input logic [4:0] exRd, input logic exLoad,
                                     input logic redirect, input logic [31:0] target,
                                     input logic memReq, input logic ready);
        stim_t s;
        s.rs1 = rs1; s.rs2 = rs2; s.uses1 = uses1; s.uses2 = uses2;
        s.exRd = exRd; s.exLoad = exLoad; s.redirect = redirect; s.target = target;
        s.memReq = memReq; s.ready = ready;
        return s;
    endfunction

    function automatic logic [7:0] ctrlBits();
        return {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
                if_id_flush, id_ex_flush, mem_wb_flush, pc_redirect};
    endfunction

    task automatic applyStimulus(input stim_t s);
        id_rs1_addr        = s.rs1;
        id_rs2_addr        = s.rs2;
        id_uses_rs1        = s.uses1;
        id_uses_rs2        = s.uses2;
        ex_rd_addr         = s.exRd;
        ex_mem_read        = s.exLoad;
        ex_redirect        = s.redirect;
        ex_redirect_target = s.target;
        mem_req            = s.memReq;
        dmem_ready         = s.ready;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Asynchronous reset pulse placed mid low-phase, away from any clock edge.
    task automatic pulseReset();
        #1 reset = 1'b1;
        #1 reset = 1'b0;
    endtask

    initial begin
        idle = mkStim(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

        vectors[0]  = '{"idle",            idle, CTRL_NONE};
        vectors[1]  = '{"loaduse_rs2",     mkStim(5'd1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0), CTRL_LOADUSE};
        vectors[2]  = '{"loaduse_rs1",     mkStim(5'd7, 5'd2, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0), CTRL_LOADUSE};
        vectors[3]  = '{"rs1_match_unused",mkStim(5'd7, 5'd2, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0), CTRL_NONE};
        vectors[4]  = '{"loaduse_x0",      mkStim(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0), CTRL_NONE};
        vectors[5]  = '{"match_not_load",  mkStim(5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0), CTRL_NONE};
        vectors[6]  = '{"redirect_over_lu",mkStim(5'd1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 32'h40, 1'b0, 1'b0), CTRL_REDIRECT};
        vectors[7]  = '{"memwait_over_all",mkStim(5'd1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 32'h44, 1'b1, 1'b0), CTRL_MEMWAIT};
        vectors[8]  = '{"ready_redirect",  mkStim(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 32'hDEAD_BEEC, 1'b1, 1'b1), CTRL_REDIRECT};
        vectors[9]  = '{"ready_loaduse",   mkStim(5'd9, 5'd3, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1), CTRL_LOADUSE};
        vectors[10] = '{"ready_no_req",    mkStim(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1), CTRL_NONE};
        vectors[11] = '{"memwait_only",    mkStim(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0), CTRL_MEMWAIT};

        reset = 1'b1;
        applyStimulus(idle);
        #3;
        checkOutput("reset_state", 32'(state), 32'd0);
        checkOutput("reset_ctrl", 32'(ctrlBits()), 32'(CTRL_NONE));
        checkOutput("reset_stall_cnt", stall_cycles, 32'd0);
        checkOutput("reset_flush_cnt", flush_events, 32'd0);
        checkOutput("reset_timeout", 32'(dmem_timeout), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Combinational table: each vector is removed before the next rising edge.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            applyStimulus(vectors[i].stim);
            #1;
            checkOutput(vectors[i].name, 32'(ctrlBits()), 32'(vectors[i].expCtrl));
            checkOutput({vectors[i].name, "_target"}, pc_redirect_target, vectors[i].stim.target);
            checkOutput({vectors[i].name, "_state"}, 32'(state), 32'd0);
            #1;
            applyStimulus(idle);
        end

        // Load-use held for exactly one cycle.
        @(negedge clk);
        pulseReset();
        applyStimulus(mkStim(5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0));
        #1 checkOutput("seq_lu_ctrl", 32'(ctrlBits()), 32'(CTRL_LOADUSE));
        @(negedge clk);
        applyStimulus(idle);
        #1;
        checkOutput("seq_lu_clear", 32'(ctrlBits()), 32'(CTRL_NONE));
        checkOutput("seq_lu_stall_cnt", stall_cycles, 32'd1);
        checkOutput("seq_lu_flush_cnt", flush_events, 32'd0);

        // Redirect with load-use active for one cycle.
        @(negedge clk);
        pulseReset();
        applyStimulus(mkStim(5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 32'h40, 1'b0, 1'b0));
        #1 checkOutput("seq_rd_ctrl", 32'(ctrlBits()), 32'(CTRL_REDIRECT));
        @(negedge clk);
        applyStimulus(idle);
        #1;
        checkOutput("seq_rd_flush_cnt", flush_events, 32'd1);
        checkOutput("seq_rd_stall_cnt", stall_cycles, 32'd0);

        // Memory wait: three not-ready cycles with a pending redirect, then ready.
        @(negedge clk);
        pulseReset();
        applyStimulus(mkStim(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 32'h80, 1'b1, 1'b0));
        for (int c = 1; c <= 3; c++) begin
            #1;
            checkOutput($sformatf("seq_mw_ctrl_c%0d", c), 32'(ctrlBits()), 32'(CTRL_MEMWAIT));
            checkOutput($sformatf("seq_mw_state_c%0d", c), 32'(state), (c == 1) ? 32'd0 : 32'd1);
            @(negedge clk);
        end
        dmem_ready = 1'b1;
        #1;
        checkOutput("seq_mw_c4_ctrl", 32'(ctrlBits()), 32'(CTRL_REDIRECT));
        checkOutput("seq_mw_c4_target", pc_redirect_target, 32'h80);
        @(negedge clk);
        applyStimulus(idle);
        #1;
        checkOutput("seq_mw_state_after", 32'(state), 32'd0);
        checkOutput("seq_mw_stall_cnt", stall_cycles, 32'd3);
        checkOutput("seq_mw_flush_cnt", flush_events, 32'd1);

        // Reset while in MEM_WAIT clears everything without a clock edge.
        @(negedge clk);
        applyStimulus(mkStim(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0));
        @(negedge clk);
        #1 checkOutput("seq_rstmw_pre_state", 32'(state), 32'd1);
        applyStimulus(idle);
        reset = 1'b1;
        #1;
        checkOutput("seq_rstmw_state", 32'(state), 32'd0);
        checkOutput("seq_rstmw_stall_cnt", stall_cycles, 32'd0);
        checkOutput("seq_rstmw_ctrl", 32'(ctrlBits()), 32'(CTRL_NONE));
        reset = 1'b0;

        // Timeout: ready held low until the trap fires.
        @(negedge clk);
        applyStimulus(mkStim(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0));
        for (int c = 1; c <= TMO; c++) begin
            #1 checkOutput($sformatf("seq_to_state_c%0d", c), 32'(state), (c == 1) ? 32'd0 : 32'd1);
            @(negedge clk);
        end
        #1;
        checkOutput("seq_to_state", 32'(state), 32'd2);
        checkOutput("seq_to_flag", 32'(dmem_timeout), 32'd1);
        checkOutput("seq_to_ctrl", 32'(ctrlBits()), 32'(CTRL_MEMWAIT));
        checkOutput("seq_to_stall_cnt", stall_cycles, 32'd4);
        // ERROR ignores ready and redirect and never leaves on its own.
        applyStimulus(mkStim(5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 32'h40, 1'b1, 1'b1));
        repeat (3) @(negedge clk);
        #1;
        checkOutput("seq_err_state", 32'(state), 32'd2);
        checkOutput("seq_err_ctrl", 32'(ctrlBits()), 32'(CTRL_MEMWAIT));
        checkOutput("seq_err_stall_cnt", stall_cycles, 32'd4);
        checkOutput("seq_err_flush_cnt", flush_events, 32'd0);

        // Reset while in ERROR.
        applyStimulus(idle);
        reset = 1'b1;
        #1;
        checkOutput("seq_rsterr_state", 32'(state), 32'd0);
        checkOutput("seq_rsterr_flag", 32'(dmem_timeout), 32'd0);
        checkOutput("seq_rsterr_ctrl", 32'(ctrlBits()), 32'(CTRL_NONE));
        checkOutput("seq_rsterr_stall_cnt", stall_cycles, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        #1 checkOutput("seq_rsterr_idle_state", 32'(state), 32'd0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
